// File: rtl/alu_mc_if.sv
// alu_mc_if: start/busy/done request bus between control unit and alu_mc.
// master drives the request, slave returns status and the registered result.
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic [3:0]       ALUControl;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output start, srcA, srcB, ALUControl,
    input  busy, done, result, zero
  );

  modport slave (
    input  start, srcA, srcB, ALUControl,
    output busy, done, result, zero
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle rv32i ALU, registered result/zero, start/busy/done.
// Define ALU_MC_MULDIV_EN to build the iterative RV32M multiply/divide unit.
module alu_mc #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input logic     clk,
  input logic     rst_n,
  alu_mc_if.slave bus
);

  logic             r_done;
  logic             r_zero;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_alu;
  logic [SHW-1:0]   w_sh;
  logic             w_busy;
  logic             w_acc;

  assign w_sh       = bus.srcB[SHW-1:0];
  assign w_acc      = bus.start & ~w_busy;
  assign bus.busy   = w_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.zero   = r_zero;

  always_comb begin
    w_alu = '0;
    case (bus.ALUControl)
      4'b0000: w_alu = bus.srcA + bus.srcB;
      4'b0001: w_alu = bus.srcA - bus.srcB;
      4'b0010: w_alu = bus.srcA & bus.srcB;
      4'b0011: w_alu = bus.srcA | bus.srcB;
      4'b0100: w_alu = bus.srcA ^ bus.srcB;
      4'b0101: w_alu = {{(WIDTH-1){1'b0}},
                        $signed(bus.srcA) < $signed(bus.srcB)};
      4'b0110: w_alu = {{(WIDTH-1){1'b0}}, bus.srcA < bus.srcB};
      4'b0111: w_alu = bus.srcA << w_sh;
      4'b1000: w_alu = bus.srcA >> w_sh;
      4'b1001: w_alu = $unsigned($signed(bus.srcA) >>> w_sh);
      default: w_alu = '0;
    endcase
  end

`ifdef ALU_MC_MULDIV_EN

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           r_state;
  logic             r_busy;
  logic [SHW-1:0]   r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_a;
  logic             r_sa;
  logic             r_sb;
  logic             r_bz;

  logic             w_multi;
  logic             w_sgn;
  logic [WIDTH:0]   w_msum;
  logic [WIDTH:0]   w_rsh;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_r;
  logic [WIDTH-1:0] w_fix;

  assign w_busy  = r_busy;
  assign w_multi = bus.ALUControl[3]
                 & (bus.ALUControl[2] | bus.ALUControl[1]);
  assign w_sgn   = bus.ALUControl[2] & ~bus.ALUControl[0];

  // mul: {r_hi,r_lo} shifts right, multiplicand added into r_hi
  assign w_msum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  // div: r_hi is the partial remainder, quotient shifts into r_lo
  assign w_rsh  = {r_hi, r_lo[WIDTH-1]};
  assign w_diff = w_rsh - {1'b0, r_b};

  assign w_q = (r_sa ^ r_sb) ? -r_lo : r_lo;
  assign w_r = r_sa ? -r_hi : r_hi;

  always_comb begin
    w_fix = '0;
    unique case (1'b1)
      ~r_op[2] & ~r_op[0]:          w_fix = r_lo;
      ~r_op[2] &  r_op[0]:          w_fix = r_hi;
       r_op[2] & ~r_op[1] &  r_bz:  w_fix = '1;
       r_op[2] & ~r_op[1] & ~r_bz:  w_fix = w_q;
       r_op[2] &  r_op[1] &  r_bz:  w_fix = r_a;
       r_op[2] &  r_op[1] & ~r_bz:  w_fix = w_r;
      default:                      w_fix = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_cnt    <= '0;
      r_op     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_a      <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_bz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_acc && w_multi) begin
            r_op    <= bus.ALUControl[2:0];
            r_a     <= bus.srcA;
            r_sa    <= w_sgn & bus.srcA[WIDTH-1];
            r_sb    <= w_sgn & bus.srcB[WIDTH-1];
            r_lo    <= (w_sgn & bus.srcA[WIDTH-1]) ? -bus.srcA : bus.srcA;
            r_b     <= (w_sgn & bus.srcB[WIDTH-1]) ? -bus.srcB : bus.srcB;
            r_bz    <= (bus.srcB == '0);
            r_hi    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= CALC;
          end else if (w_acc) begin
            r_result <= w_alu;
            r_zero   <= (w_alu == '0);
            r_done   <= 1'b1;
          end
        end
        CALC: begin
          if (r_op[2]) begin
            r_hi <= w_diff[WIDTH] ? w_rsh[WIDTH-1:0] : w_diff[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};
          end else begin
            r_hi <= w_msum[WIDTH:1];
            r_lo <= {w_msum[0], r_lo[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == SHW'(WIDTH - 1)) r_state <= FIX;
        end
        FIX: begin
          r_result <= w_fix;
          r_zero   <= (w_fix == '0);
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`else

  // mul/div codes fall through w_alu's default and complete as zero
  assign w_busy = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done   <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else begin
      r_done <= w_acc;
      if (w_acc) begin
        r_result <= w_alu;
        r_zero   <= (w_alu == '0);
      end
    end
  end

`endif

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vectors plus a per-cycle reference model for alu_mc.
// Follows ALU_MC_MULDIV_EN so the same bench covers both builds.
module tb_alu_mc;

  localparam int W  = 32;
  localparam int SH = $clog2(W);
`ifdef ALU_MC_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  localparam int MLAT = MD ? W + 2 : 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  alu_mc_if #(.WIDTH(W)) bus();

  alu_mc #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] md(logic [W-1:0] v);
    return MD ? v : '0;
  endfunction

  function automatic bit is_multi(logic [3:0] op);
    return MD && (op >= 4'hA);
  endfunction

  function automatic logic [W-1:0] model(logic [3:0] op,
                                         logic [W-1:0] a,
                                         logic [W-1:0] b);
    logic [2*W-1:0]      p;
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    logic [W-1:0]        r;
    logic [W-1:0]        mn;
    bit                  ov;
    sa = a;
    sb = b;
    p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    mn = {1'b1, {(W-1){1'b0}}};
    ov = (a == mn) && (b == '1);
    r  = '0;
    case (op)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = (sa < sb) ? 1 : 0;
      4'h6: r = (a < b) ? 1 : 0;
      4'h7: r = a << b[SH-1:0];
      4'h8: r = a >> b[SH-1:0];
      4'h9: r = sa >>> b[SH-1:0];
      4'hA: r = p[W-1:0];
      4'hB: r = p[2*W-1:W];
      4'hC: r = (b == 0) ? '1 : ov ? a : sa / sb;
      4'hD: r = (b == 0) ? '1 : a / b;
      4'hE: r = (b == 0) ? a : ov ? '0 : sa % sb;
      default: r = (b == 0) ? a : a % b;
    endcase
    if (!MD && op >= 4'hA) r = '0;
    return r;
  endfunction

  typedef struct {
    int           cyc;
    logic [W-1:0] res;
  } pend_t;

  pend_t        q[$];
  logic         s_req = 1'b0;
  logic [3:0]   s_op;
  logic [W-1:0] s_a;
  logic [W-1:0] s_b;
  logic [W-1:0] m_res = '0;
  bit           m_busy = 1'b0;

  always @(posedge clk) begin
    cyc++;
    s_req = bus.start && rst_n;
    s_op  = bus.ALUControl;
    s_a   = bus.srcA;
    s_b   = bus.srcB;
  end

  always @(negedge clk) begin
    bit    e_done;
    pend_t p;
    e_done = 1'b0;
    if (!rst_n) begin
      q.delete();
      m_res  = '0;
      m_busy = 1'b0;
    end else begin
      if (s_req && !m_busy) begin
        p.cyc = cyc + (is_multi(s_op) ? W + 1 : 0);
        p.res = model(s_op, s_a, s_b);
        q.push_back(p);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e_done = 1'b1;
        m_res  = q[0].res;
        void'(q.pop_front());
      end
      m_busy = (q.size() > 0);
    end
    chk("cmp_done", W'(bus.done), W'(e_done));
    chk("cmp_busy", W'(bus.busy), W'(m_busy));
    chk("cmp_result", bus.result, m_res);
    chk("cmp_zero", W'(bus.zero), W'(m_res == '0));
  end

  task automatic run(string nm, logic [3:0] c, logic [W-1:0] a,
                     logic [W-1:0] b, logic [W-1:0] exp, int lat);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    @(negedge clk);
    #1;
    bus.start      = 1'b1;
    bus.ALUControl = c;
    bus.srcA       = a;
    bus.srcB       = b;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      got = bus.done;
      #1 bus.start = 1'b0;
    end
    chk({nm, "_lat"}, W'(n), W'(lat));
    chk(nm, bus.result, exp);
    chk({nm, "_zero"}, W'(bus.zero), W'(exp == '0));
  endtask

  initial begin
    int           n;
    int           nd;
    int           d1;
    int           d2;
    int           cnt;
    logic [W-1:0] r1;
    logic [W-1:0] r2;

    bus.start      = 1'b0;
    bus.ALUControl = '0;
    bus.srcA       = '0;
    bus.srcB       = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", W'(bus.busy), '0);
    chk("rst_done", W'(bus.done), '0);
    chk("rst_result", bus.result, '0);
    chk("rst_zero", W'(bus.zero), W'(1));
    #1 rst_n = 1'b1;

    chk("model_slt", model(4'h5, 32'hFFFFFFFF, 32'h1), 32'h1);
    chk("model_sra", model(4'h9, 32'h80000000, 32'h24), 32'hF8000000);
    chk("model_rem", model(4'hE, 32'hFFFFFFF9, 32'h2), md(32'hFFFFFFFF));
    chk("model_divov", model(4'hC, 32'h80000000, 32'hFFFFFFFF),
        md(32'h80000000));
    chk("model_mulhu", model(4'hB, 32'h00010000, 32'h00010001),
        md(32'h1));

    run("sub",  4'h1, 32'h5, 32'h5, 32'h0, 1);
    run("add",  4'h0, 32'hFFFFFFFF, 32'h2, 32'h1, 1);
    run("and",  4'h2, 32'hF0F01234, 32'h0FF0FFFF, 32'h00F01234, 1);
    run("or",   4'h3, 32'hF0000000, 32'h0000000F, 32'hF000000F, 1);
    run("xor",  4'h4, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1);
    run("slt",  4'h5, 32'hFFFFFFFF, 32'h1, 32'h1, 1);
    run("sltu", 4'h6, 32'hFFFFFFFF, 32'h1, 32'h0, 1);
    run("sll",  4'h7, 32'h1, 32'h2F, 32'h00008000, 1);
    run("srl",  4'h8, 32'h80000000, 32'h4, 32'h08000000, 1);
    run("sra",  4'h9, 32'h80000000, 32'h24, 32'hF8000000, 1);

    run("mul",   4'hA, 32'h00010000, 32'h00010001, md(32'h00010000), MLAT);
    run("mulhu", 4'hB, 32'h00010000, 32'h00010001, md(32'h1), MLAT);
    run("mul34", 4'hA, 32'h3, 32'h4, md(32'hC), MLAT);
    run("div",   4'hC, 32'hFFFFFFF9, 32'h2, md(32'hFFFFFFFD), MLAT);
    run("rem",   4'hE, 32'hFFFFFFF9, 32'h2, md(32'hFFFFFFFF), MLAT);
    run("divu0", 4'hD, 32'h7, 32'h0, md(32'hFFFFFFFF), MLAT);
    run("remu0", 4'hF, 32'h7, 32'h0, md(32'h7), MLAT);
    run("div0",  4'hC, 32'hFFFFFFF9, 32'h0, md(32'hFFFFFFFF), MLAT);
    run("rem0",  4'hE, 32'hFFFFFFF9, 32'h0, md(32'hFFFFFFF9), MLAT);
    run("divov", 4'hC, 32'h80000000, 32'hFFFFFFFF, md(32'h80000000), MLAT);
    run("remov", 4'hE, 32'h80000000, 32'hFFFFFFFF, 32'h0, MLAT);
    run("divu",  4'hD, 32'd100, 32'd7, md(32'd14), MLAT);
    run("remu",  4'hF, 32'd100, 32'd7, md(32'd2), MLAT);

    @(negedge clk);
    #1;
    bus.start      = 1'b1;
    bus.ALUControl = 4'hC;
    bus.srcA       = 32'd1000;
    bus.srcB       = 32'd3;
    @(negedge clk);
    #1 bus.start = 1'b0;
    repeat (8) @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", W'(bus.busy), '0);
    chk("midrst_done", W'(bus.done), '0);
    chk("midrst_result", bus.result, '0);
    chk("midrst_zero", W'(bus.zero), W'(1));
    #1 rst_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
    chk("midrst_no_done", W'(cnt), '0);

    @(negedge clk);
    #1;
    bus.start      = 1'b1;
    bus.ALUControl = 4'hD;
    bus.srcA       = 32'd100;
    bus.srcB       = 32'd7;
    n  = 0;
    nd = 0;
    d1 = 0;
    d2 = 0;
    r1 = '0;
    r2 = '0;
    while (nd < 2 && n < 80) begin
      @(negedge clk);
      n++;
      if (bus.done) begin
        nd++;
        if (nd == 1) begin
          d1 = n;
          r1 = bus.result;
        end else begin
          d2 = n;
          r2 = bus.result;
        end
      end
      if (n == 1) begin
        #1;
        bus.ALUControl = 4'h0;
        bus.srcA       = 32'd1;
        bus.srcB       = 32'd2;
      end
    end
    #1 bus.start = 1'b0;
    chk("hold_first_lat", W'(d1), W'(MLAT));
    chk("hold_first_res", r1, md(32'd14));
    chk("hold_b2b_lat", W'(d2), W'(MLAT + 1));
    chk("hold_b2b_res", r2, 32'd3);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
